iob_fifo_read_stream: RTL and testbench

//  Read-side consumer for iob_fifo_sync/iob_fifo_async read ports: drains frames of len_i words

---
 rtl/iob_fifo_read_stream.sv | 107 ++++++++++
 tb/tb_iob_fifo_read_stream.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_fifo_read_stream.sv
// iob_fifo_read_stream: drains len_i-word frames from a 1-cycle-latency FIFO read port into a valid/ready stream with tlast
module iob_fifo_read_stream #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LEN_W-1:0]  count_o,
    output logic              fifo_read_o,
    input  logic [DATA_W-1:0] fifo_rdata_i,
    input  logic              fifo_empty_i,
    output logic              tvalid_o,
    input  logic              tready_i,
    output logic [DATA_W-1:0] tdata_o,
    output logic              tlast_o
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, rd_cnt_q, rd_cnt_d, count_q, count_d;
    logic              inflight_q, inflight_d, done_q, done_d;
    logic [1:0]        buf_cnt_q, buf_cnt_d, cnt_pop;
    logic [DATA_W-1:0] b0_q, b0_d, b1_q, b1_d;
    logic              run, pop, last;

    assign run      = state_q == RUN;
    assign tvalid_o = buf_cnt_q != 2'd0;
    assign tdata_o  = b0_q;
    assign last     = count_q == len_q - LEN_W'(1);
    assign tlast_o  = tvalid_o & last;
    assign pop      = tvalid_o & tready_i;
    assign cnt_pop  = buf_cnt_q - {1'b0, pop};
    assign busy_o   = run;
    assign done_o   = done_q;
    assign count_o  = count_q;
    // Reads are also held off during a sync clear so the FIFO never loses a word that would be discarded
    assign fifo_read_o = cke_i & ~rst_i & run & en_i & ~fifo_empty_i & (rd_cnt_q < len_q)
                       & (({1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);

    // Next state: frame control, read counter, 2-entry FIFO-ordered skid buffer (pop shifts, capture appends)
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q + LEN_W'(fifo_read_o);
        count_d    = count_q + LEN_W'(pop);
        inflight_d = fifo_read_o;
        done_d     = 1'b0;
        b0_d       = pop ? b1_q : b0_q;
        b1_d       = b1_q;
        buf_cnt_d  = cnt_pop + {1'b0, inflight_q};
        if (inflight_q) begin
            if (cnt_pop == 2'd0) b0_d = fifo_rdata_i;
            else b1_d = fifo_rdata_i;
        end
        if (!run && en_i && len_i != '0) begin
            state_d = RUN;
            len_d   = len_i;
        end
        if (run && pop && last) begin
            state_d  = IDLE;
            rd_cnt_d = '0;
            count_d  = '0;
            done_d   = 1'b1;
        end
        if (rst_i) begin
            state_d    = IDLE;
            len_d      = '0;
            rd_cnt_d   = '0;
            count_d    = '0;
            inflight_d = 1'b0;
            done_d     = 1'b0;
            buf_cnt_d  = 2'd0;
            b0_d       = '0;
            b1_d       = '0;
        end
    end

    // State registers: async clear, otherwise advance only when the clock enable is high
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            buf_cnt_q  <= 2'd0;
            b0_q       <= '0;
            b1_q       <= '0;
        end else if (cke_i) begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            buf_cnt_q  <= buf_cnt_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
        end
    end
endmodule

// File: tb/tb_iob_fifo_read_stream.sv
// tb_iob_fifo_read_stream: scoreboard bench with a FIFO array model and per-frame expected word queues
module tb_iob_fifo_read_stream;
    localparam int DW = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          arst, cke, rst, en, busy, done, frd, empty, tvalid, tready, tlast;
    logic [LW-1:0] len, count;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] tdata;

    typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;

    logic [DW-1:0] mem [0:1023];
    int            rd_ptr = 0;
    int            wr_ptr = 0;
    int            pass_n = 0;
    int            chk_n = 0;
    int            mode = 0;
    int            acc_cnt = 0;
    int            outst = 0;
    logic          rd_pend = 1'b0;
    logic          exp_done = 1'b0;
    logic          stl = 1'b0;
    logic          stl_l = 1'b0;
    logic [DW-1:0] stl_d = '0;
    logic          acc;
    logic          room;
    beat_t         b;
    beat_t         sb[$];

    always #5 clk = ~clk;

    assign empty = rd_ptr >= wr_ptr;

    iob_fifo_read_stream #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk_i(clk), .arst_i(arst), .cke_i(cke), .rst_i(rst), .en_i(en), .len_i(len),
        .busy_o(busy), .done_o(done), .count_o(count), .fifo_read_o(frd),
        .fifo_rdata_i(rdata), .fifo_empty_i(empty), .tvalid_o(tvalid), .tready_i(tready),
        .tdata_o(tdata), .tlast_o(tlast)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        chk_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // FIFO model: 1-cycle read latency, word k of the stream is mem[k]
    always @(posedge clk) begin
        if (rd_pend) begin
            rdata  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Monitor: sampled mid-cycle; the values seen here are the ones the next clock edge acts on
    always @(negedge clk) begin
        if (arst || (rst && cke)) begin
            rd_pend  = frd & cke;
            outst    = 0;
            acc_cnt  = 0;
            exp_done = 1'b0;
            stl      = 1'b0;
        end else begin
            chk("done", done, exp_done);
            if (stl) begin
                chk("stall_valid", tvalid, 1);
                chk("stall_data", tdata, stl_d);
                chk("stall_last", tlast, stl_l);
            end
            acc  = tvalid & tready & cke;
            room = (outst - int'(acc)) < 2;
            if (frd) begin
                chk("read_with_en", en, 1);
                chk("read_not_empty", empty, 0);
                chk("read_room", room, 1);
            end
            b = '0;
            if (acc) begin
                if (sb.size() == 0) chk("unexpected_beat", 0, 1);
                else begin
                    b = sb.pop_front();
                    chk("tdata", tdata, b.d);
                    chk("tlast", tlast, b.l);
                    chk("count", count, acc_cnt);
                end
            end
            if (cke) begin
                exp_done = acc & b.l;
                outst    = outst + int'(frd) - int'(acc);
                acc_cnt  = acc ? (b.l ? 0 : acc_cnt + 1) : acc_cnt;
            end
            rd_pend = frd & cke;
            stl     = tvalid & ~(tready & cke);
            stl_d   = tdata;
            stl_l   = tlast;
        end
    end

    // Sink: 0 = always ready, 1 = toggling, 2 = random
    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tready = mode == 0 ? 1'b1 : mode == 1 ? ~tready : ($urandom_range(0, 2) != 0);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input int l, output int st);
        int t = 0;
        while (busy && t < 100) begin
            tick();
            t++;
        end
        chk("idle_before_start", busy, 0);
        st = rd_ptr;
        for (int i = 0; i < l; i++) sb.push_back({mem[st + i], i == l - 1});
        en  = 1'b1;
        len = LW'(l);
        tick();
        len = '0;
    endtask

    task automatic finish_frame(input int l, input int st, input bit ren);
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 3000) begin
            if (ren) en = $urandom_range(0, 3) != 0;
            tick();
            t++;
        end
        en = 1'b1;
        chk("frame_in_time", t < 3000, 1);
        chk("frame_reads", rd_ptr - st, l);
        chk("busy_after", busy, 0);
        chk("count_after", count, 0);
        tick();
    endtask

    task automatic wait_until_rd(input int target);
        int t = 0;
        while (rd_ptr < target && t < 200) begin
            tick();
            t++;
        end
        chk("reach_read", rd_ptr, target);
    endtask

    task automatic wait_until_acc(input int target);
        int t = 0;
        while (acc_cnt < target && t < 200) begin
            tick();
            t++;
        end
        chk("reach_beat", acc_cnt, target);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tvalid"}, tvalid, 0);
        chk({tag, "_tdata"}, tdata, 0);
        chk({tag, "_tlast"}, tlast, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_fifo_read"}, frd, 0);
    endtask

    initial begin
        int st, l;
        logic [DW-1:0] hd;
        logic [LW-1:0] hc;
        for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 16; i++) mem[i] = DW'(i);
        arst = 1'b1; cke = 1'b1; rst = 1'b0; en = 1'b0; len = '0;
        tick(2);
        chk_zero("reset");
        arst = 1'b0;
        tick();

        // 1: 16 words 0..15, always ready: first beat 3 cycles after start, then 1 word/cycle
        wr_ptr = 16;
        mode = 0;
        start(16, st);
        chk("lat_c1", tvalid, 0);
        tick();
        chk("lat_c2", tvalid, 0);
        tick();
        chk("lat_c3", tvalid, 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("throughput", tvalid, 1);
        end
        finish_frame(16, st, 0);

        // 2: 20 words available, frame of 8, random sink
        wr_ptr = rd_ptr + 20;
        mode = 2;
        start(8, st);
        finish_frame(8, st, 0);
        chk("fifo_left", wr_ptr - rd_ptr, 12);

        // 3: toggling sink, plus a clock-enable freeze mid-frame
        wr_ptr = rd_ptr + 10;
        mode = 1;
        start(10, st);
        tick(4);
        cke = 1'b0;
        hd = tdata;
        hc = count;
        tick(3);
        chk("cke_hold_data", tdata, hd);
        chk("cke_hold_count", count, hc);
        cke = 1'b1;
        finish_frame(10, st, 0);

        // 4: FIFO runs dry after word 3 for 5 cycles
        mode = 0;
        wr_ptr = rd_ptr + 4;
        start(10, st);
        wait_until_rd(st + 4);
        tick(5);
        chk("dry_drained", tvalid, 0);
        chk("dry_beats", acc_cnt, 4);
        wr_ptr = st + 10;
        finish_frame(10, st, 0);

        // 5: en low for 4 cycles after the 2nd read
        wr_ptr = rd_ptr + 8;
        start(8, st);
        wait_until_rd(st + 2);
        en = 1'b0;
        tick(4);
        chk("en_low_no_reads", rd_ptr - st, 2);
        en = 1'b1;
        finish_frame(8, st, 0);

        // 6: async reset at beat 5 of 12, then a 3-word frame and a zero-length start
        wr_ptr = rd_ptr + 12;
        start(12, st);
        wait_until_acc(5);
        arst = 1'b1;
        sb.delete();
        #1;
        chk_zero("arst");
        tick();
        arst = 1'b0;
        tick();
        start(3, st);
        finish_frame(3, st, 0);
        en = 1'b1;
        len = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("len0_busy", busy, 0);
            chk("len0_read", frd, 0);
        end

        // synchronous clear mid-frame
        wr_ptr = rd_ptr + 6;
        start(6, st);
        wait_until_acc(2);
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        chk_zero("srst");
        tick();

        // random frames with random sink and random en pauses
        mode = 2;
        for (int k = 0; k < 8; k++) begin
            l = $urandom_range(1, 20);
            wr_ptr = rd_ptr + l + $urandom_range(0, 3);
            start(l, st);
            finish_frame(l, st, 1);
        end

        tick(3);
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end
endmodule
